mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory of the multicycle core between two requesters: instruction fetch (I port) and load/store (D port).
- Arbitrates between them, sequences one memory access at a time and returns read data plus a one-cycle done pulse to the winner.
- Sits between the main control FSM / datapath and the memory. The control FSM only raises requests and waits for done; it no longer drives memory enables directly.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- MEM_LAT, 1, memory read latency in cycles (legal range 1..7).
- MAX_D_STREAK, 4, number of consecutive D grants allowed while i_req is pending before I is forced to win (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request; held high with i_addr stable until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_done  out  1  one-cycle completion pulse for I.
- i_rdata  out  DATA_W  registered fetch data.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle completion pulse for D.
- d_rdata  out  DATA_W  registered load data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction in progress.
- owner  out  1  0 = I, 1 = D; meaningful only while busy.

Behaviour:
- Reset: all outputs 0; state IDLE; streak counter 0; latched addr/wdata/we all 0. Reset mid-transaction aborts it: no done pulse is issued and memory is not written after rst rises.
- FSM states and transitions:
  - IDLE: sample requests. No request → stay. Otherwise latch winner, addr, wdata, we → ACCESS.
  - ACCESS, 1 cycle: mem_addr and mem_wdata come from the latched values; mem_we = latched we, and this is the only cycle mem_we can be 1. Write → RESP; read → WAIT with counter = MEM_LAT.
  - WAIT: counter decrements each cycle. mem_addr stays held. In the last WAIT cycle (counter == 1), capture mem_rdata into the owner's rdata register → RESP.
  - RESP, 1 cycle: pulse the owner's done; requests are not sampled → IDLE.
- Latency, with a request sampled in IDLE in cycle k:
  - Write: done in cycle k+2.
  - Read: done in cycle k+2+MEM_LAT.
  - Minimum spacing between back-to-back accesses is 3 cycles for writes and 3+MEM_LAT for reads.
- Memory contract: the memory samples mem_addr at the end of ACCESS, and mem_rdata is valid in the cycle MEM_LAT cycles later.
- Arbitration when both requests are high in IDLE:
  - D wins, unless streak == MAX_D_STREAK, in which case I wins.
  - A D grant with i_req high increments streak (saturating).
  - An I grant, or a D grant with i_req low, clears streak.
- Request handshake:
  - A req still high in the IDLE cycle after RESP counts as a new request.
  - A requester wanting one access drops req no later than the cycle its done is high.
  - A req dropped mid-transaction does not cancel it: the access completes and done still pulses.
- rdata registers change only when a read completes for that port. A write never alters i_rdata or d_rdata.
- i_done and d_done are never high in the same cycle.
- busy = (state != IDLE). owner holds its latched value from ACCESS through RESP.
- In IDLE: mem_we = 0 and mem_addr = last latched address.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - typedef arb_state_t {IDLE, ACCESS, WAIT, RESP};
  - typedef owner_t {OWN_I = 0, OWN_D = 1};
  - localparams for latency counter width (3) and streak counter width (4).
- One natural sub-module: arb_pick, combinational winner select plus the registered streak counter. The FSM and datapath latches stay in mem_port_arbiter.

Test Plan:
- Single load, MEM_LAT = 1: d_req = 1, d_addr = 0x40, memory returns 0x1122334455667788 → d_done only in cycle k+3, d_rdata = 0x1122334455667788, mem_we never high.
- Single store: d_we = 1, d_addr = 0x80, d_wdata = 0xDEAD → mem_we high only in cycle k+1 with mem_addr = 0x80, d_done in k+2, d_rdata unchanged.
- Simultaneous i_req/d_req, i_addr = 0x0, d_addr = 0x100 → D served first, then I. Check owner sequence 1 then 0, and i_done is never coincident with d_done.
- Starvation, MAX_D_STREAK = 4: i_req held high while D issues 6 back-to-back loads → exactly 4 D grants, then an I grant, then D resumes.
- MEM_LAT = 3 fetch of 0x200 → i_done in k+5, i_rdata captured from the last WAIT cycle, mem_addr = 0x200 throughout ACCESS and WAIT.
- rst asserted during WAIT of a load → all outputs 0 immediately, no d_done, next request after release behaves as first access.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: types and widths shared by the memory port arbiter and its
// winner-select helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Read latency counter holds MEM_LAT (1..7).
  localparam int LAT_CNT_W = 3;
  // Consecutive-D-grant counter holds up to MAX_D_STREAK (1..15).
  localparam int STREAK_W  = 4;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select between fetch (I) and load/store (D)
// plus the registered D-streak counter that bounds how long I can starve.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   iReq      fetch request
//   dReq      load/store request
//   grantEn   a grant is being taken this cycle (arbiter idle, any request)
//   winner    OWN_D or OWN_I; valid whenever grantEn is high
module arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   iReq,
  input  logic   dReq,
  input  logic   grantEn,
  output owner_t winner
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;

  // D wins by default; once I has watched MAX_D_STREAK D grants go by it is
  // forced through.
  always_comb begin
    winner = OWN_I;
    if (dReq && !(iReq && (streak == STREAK_MAX))) begin
      winner = OWN_D;
    end
  end

  // Only a D grant taken over a waiting I extends the streak; anything else
  // means I is not being held off, so the count restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (grantEn) begin
      if ((winner == OWN_D) && iReq) begin
        if (streak != '1) begin
          streak <= streak + 1'b1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port instruction/data memory between
// instruction fetch (I) and load/store (D). One access at a time; the
// winner gets registered read data and a one-cycle done pulse.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   i_req, i_addr                   fetch request, held until i_done
//   i_done, i_rdata                 fetch completion pulse and data
//   d_req, d_we, d_addr, d_wdata    load/store request, held until d_done
//   d_done, d_rdata                 load/store completion pulse and load data
//   mem_addr, mem_wdata, mem_we     memory command (from latched values)
//   mem_rdata                       memory read data, valid MEM_LAT cycles
//                                   after the ACCESS cycle
//   busy, owner                     transaction in progress / its owner
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample requests, latch winner/addr/wdata/we on any request
// ACCESS | drive command; the only cycle mem_we can be high
// WAIT   | read latency down-count; capture mem_rdata when count is 1
// RESP   | pulse the owner's done; requests are not sampled
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(1);

  arb_state_t           state;
  arb_state_t           stateNext;
  owner_t               winner;
  owner_t               ownerQ;
  logic [ADDR_W-1:0]    addrQ;
  logic [DATA_W-1:0]    wdataQ;
  logic                 weQ;
  logic [LAT_CNT_W-1:0] latCnt;
  logic [DATA_W-1:0]    iRdataQ;
  logic [DATA_W-1:0]    dRdataQ;
  logic                 grantEn;
  logic                 lastWait;

  assign grantEn  = (state == IDLE) && (i_req || d_req);
  assign lastWait = (state == WAIT) && (latCnt == LAT_LAST);

  arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) uPick (
    .clk    (clk),
    .rst    (rst),
    .iReq   (i_req),
    .dReq   (d_req),
    .grantEn(grantEn),
    .winner (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantEn) stateNext = ACCESS;
      ACCESS:  stateNext = weQ ? RESP : WAIT;
      WAIT:    if (lastWait) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request latch: taken once per transaction so requesters may drop req
  // mid-access without disturbing the command on the memory pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerQ <= OWN_I;
      addrQ  <= '0;
      wdataQ <= '0;
      weQ    <= 1'b0;
    end else if (grantEn) begin
      ownerQ <= winner;
      if (winner == OWN_D) begin
        addrQ  <= d_addr;
        wdataQ <= d_wdata;
        weQ    <= d_we;
      end else begin
        addrQ  <= i_addr;
        wdataQ <= '0;
        weQ    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latCnt <= '0;
    end else if (state == ACCESS) begin
      latCnt <= LAT_LOAD;
    end else if (state == WAIT) begin
      latCnt <= latCnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iRdataQ <= '0;
      dRdataQ <= '0;
    end else if (lastWait) begin
      if (ownerQ == OWN_D) begin
        dRdataQ <= mem_rdata;
      end else begin
        iRdataQ <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign owner     = ownerQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign mem_we    = (state == ACCESS) && weQ;
  assign i_done    = (state == RESP) && (ownerQ == OWN_I);
  assign d_done    = (state == RESP) && (ownerQ == OWN_D);
  assign i_rdata   = iRdataQ;
  assign d_rdata   = dRdataQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memData(input logic [31:0] a);
    case (a)
      32'h0000_0000: memData = 64'h0123_4567_89AB_CDEF;
      32'h0000_0008: memData = 64'h0F0F_0F0F_F0F0_F0F0;
      32'h0000_0040: memData = 64'h1122_3344_5566_7788;
      32'h0000_0100: memData = 64'hA5A5_5A5A_A5A5_5A5A;
      32'h0000_0200: memData = 64'hCAFE_F00D_1234_5678;
      default:       memData = {a, ~a};
    endcase
  endfunction

  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  // MEM_LAT = 1 instance
  logic        i_req = 0, i_done, d_req = 0, d_we = 0, d_done, mem_we, busy, owner;
  logic [31:0] i_addr = 0, d_addr = 0, mem_addr;
  logic [63:0] i_rdata, d_rdata, d_wdata = 0, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // MEM_LAT = 3 instance, fetch port only
  logic        i3Req = 0, i3Done, d3Done, mem3We, busy3, owner3;
  logic [31:0] i3Addr = 0, mem3Addr;
  logic [63:0] i3Rdata, d3Rdata, mem3Wdata, mem3Rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(3), .MAX_D_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i3Req), .i_addr(i3Addr), .i_done(i3Done), .i_rdata(i3Rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(64'h0),
    .d_done(d3Done), .d_rdata(d3Rdata),
    .mem_addr(mem3Addr), .mem_wdata(mem3Wdata), .mem_we(mem3We), .mem_rdata(mem3Rdata),
    .busy(busy3), .owner(owner3)
  );

  // Memory models: data is presented only in the single cycle that lies
  // MEM_LAT cycles after the ACCESS cycle (first busy cycle), BAD otherwise.
  logic        busy1Q = 0, busy3Q = 0;
  logic [2:0]  acc1 = 0, acc3 = 0;
  logic [31:0] ap1 [0:2];
  logic [31:0] ap3 [0:2];
  initial for (int i = 0; i < 3; i++) begin ap1[i] = 0; ap3[i] = 0; end

  always @(posedge clk) begin
    busy1Q <= busy;
    busy3Q <= busy3;
    acc1   <= {acc1[1:0], busy & ~busy1Q};
    acc3   <= {acc3[1:0], busy3 & ~busy3Q};
    ap1[0] <= mem_addr;
    ap3[0] <= mem3Addr;
    for (int i = 1; i < 3; i++) begin
      ap1[i] <= ap1[i-1];
      ap3[i] <= ap3[i-1];
    end
  end
  assign mem_rdata = acc1[0] ? memData(ap1[0]) : BAD;
  assign mem3Rdata = acc3[2] ? memData(ap3[2]) : BAD;

  // Monitor for the MEM_LAT = 1 instance
  int          weCnt = 0, lastWeCyc = -1, dDoneTotal = 0, grantCnt = 0;
  logic [31:0] lastWeAddr = 0;
  logic [63:0] lastWeData = 0;
  logic [15:0] grantBits = 0;
  logic        bothDone = 0, busyN = 0;

  always @(negedge clk) begin
    busyN <= busy;
    if (mem_we) begin
      weCnt      <= weCnt + 1;
      lastWeCyc  <= cyc;
      lastWeAddr <= mem_addr;
      lastWeData <= mem_wdata;
    end
    if (busy && !busyN) begin
      grantBits <= {grantBits[14:0], owner};
      grantCnt  <= grantCnt + 1;
    end
    if (i_done && d_done) bothDone <= 1'b1;
    if (d_done) dDoneTotal <= dDoneTotal + 1;
  end

  task automatic startReq(input logic doI, input logic [31:0] ia, input logic doD,
                          input logic we, input logic [31:0] da, input logic [63:0] wd,
                          output int k);
    @(posedge clk);
    #1;
    if (doI) begin i_req = 1; i_addr = ia; end
    if (doD) begin d_req = 1; d_we = we; d_addr = da; d_wdata = wd; end
    k = cyc;
  endtask

  // Waits for nI fetch and nD data completions; each req drops in the cycle
  // of its last expected done. An exhausted budget shows up as a count miss.
  task automatic waitDones(input int nI, input int nD, input int budget,
                           output int iCyc, output int dCyc);
    int gotI, gotD;
    gotI = 0; gotD = 0; iCyc = -1; dCyc = -1;
    for (int n = 0; n < budget && (gotI < nI || gotD < nD); n++) begin
      @(negedge clk);
      if (i_done) begin gotI++; iCyc = cyc; if (gotI >= nI) i_req = 0; end
      if (d_done) begin gotD++; dCyc = cyc; if (gotD >= nD) d_req = 0; end
    end
    #1;
    checkVal("i_done_count", 64'(gotI), 64'(nI));
    checkVal("d_done_count", 64'(gotD), 64'(nD));
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_busy"},    busy,      0);
    checkVal({tag, "_owner"},   owner,     0);
    checkVal({tag, "_i_done"},  i_done,    0);
    checkVal({tag, "_d_done"},  d_done,    0);
    checkVal({tag, "_mem_we"},  mem_we,    0);
    checkVal({tag, "_mem_addr"}, mem_addr, 0);
    checkVal({tag, "_mem_wdata"}, mem_wdata, 0);
    checkVal({tag, "_i_rdata"}, i_rdata,   0);
    checkVal({tag, "_d_rdata"}, d_rdata,   0);
  endtask

  initial begin
    int k, iC, dC, g0, w0, dd0;
    logic addrBad;

    // reset
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    checkVal("reset_busy3", busy3, 0);
    @(posedge clk); #1 rst = 0;

    // single load, MEM_LAT = 1
    startReq(0, 0, 1, 0, 32'h40, 0, k);
    waitDones(0, 1, 20, iC, dC);
    checkVal("load_done_cycle", 64'(dC), 64'(k + 3));
    checkVal("load_rdata", d_rdata, 64'h1122_3344_5566_7788);
    checkVal("load_no_we", 64'(weCnt), 0);

    // single store
    startReq(0, 0, 1, 1, 32'h80, 64'hDEAD, k);
    waitDones(0, 1, 20, iC, dC);
    checkVal("store_done_cycle", 64'(dC), 64'(k + 2));
    checkVal("store_we_count", 64'(weCnt), 1);
    checkVal("store_we_cycle", 64'(lastWeCyc), 64'(k + 1));
    checkVal("store_we_addr", lastWeAddr, 32'h80);
    checkVal("store_we_data", lastWeData, 64'hDEAD);
    checkVal("store_rdata_kept", d_rdata, 64'h1122_3344_5566_7788);
    d_we = 0;

    // simultaneous requests: D then I
    g0 = grantCnt;
    startReq(1, 32'h0, 1, 0, 32'h100, 0, k);
    waitDones(1, 1, 40, iC, dC);
    checkVal("simul_d_cycle", 64'(dC), 64'(k + 3));
    checkVal("simul_i_cycle", 64'(iC), 64'(k + 7));
    checkVal("simul_grants", 64'(grantCnt - g0), 2);
    checkVal("simul_owner_seq", grantBits[1:0], 2'b10);
    checkVal("simul_i_rdata", i_rdata, 64'h0123_4567_89AB_CDEF);
    checkVal("simul_d_rdata", d_rdata, 64'hA5A5_5A5A_A5A5_5A5A);

    // starvation: I held while D streams 6 loads
    g0 = grantCnt;
    startReq(1, 32'h8, 1, 0, 32'h40, 0, k);
    waitDones(1, 6, 200, iC, dC);
    checkVal("starve_grants", 64'(grantCnt - g0), 7);
    checkVal("starve_owner_seq", grantBits[6:0], 7'b1111011);
    checkVal("starve_i_cycle", 64'(iC), 64'(k + 19));
    checkVal("starve_i_rdata", i_rdata, 64'h0F0F_0F0F_F0F0_F0F0);
    checkVal("no_coincident_done", bothDone, 0);
    checkVal("reads_no_we", 64'(weCnt), 1);

    // MEM_LAT = 3 fetch
    @(posedge clk); #1;
    i3Req = 1; i3Addr = 32'h200; k = cyc;
    iC = -1; addrBad = 0;
    for (int n = 0; n < 30 && iC < 0; n++) begin
      @(negedge clk);
      if (busy3 && !i3Done && mem3Addr != 32'h200) addrBad = 1;
      if (i3Done) begin iC = cyc; i3Req = 0; end
    end
    checkVal("lat3_done_cycle", 64'(iC), 64'(k + 5));
    checkVal("lat3_rdata", i3Rdata, 64'hCAFE_F00D_1234_5678);
    checkVal("lat3_addr_held", addrBad, 0);
    checkVal("lat3_owner", owner3, 0);

    // reset during WAIT of a load
    startReq(0, 0, 1, 0, 32'h40, 0, k);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkVal("pre_rst_busy", busy, 1);
    dd0 = dDoneTotal; w0 = weCnt;
    rst = 1; d_req = 0;
    #1;
    checkAllZero("midrst");
    repeat (3) @(negedge clk);
    checkVal("midrst_no_done", 64'(dDoneTotal), 64'(dd0));
    checkVal("midrst_no_we", 64'(weCnt), 64'(w0));
    @(posedge clk); #1 rst = 0;
    startReq(0, 0, 1, 0, 32'h100, 0, k);
    waitDones(0, 1, 20, iC, dC);
    checkVal("postrst_done_cycle", 64'(dC), 64'(k + 3));
    checkVal("postrst_rdata", d_rdata, 64'hA5A5_5A5A_A5A5_5A5A);
    checkVal("postrst_owner", grantBits[0], 1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
